spgd_dac_perturb_seq: RTL

Sequencer for the two-sided SPGD perturbation cycle on one 14-bit DAC channel.
- On each `start`, drives the DAC to base+delta, waits a programmable settle time and requests a metric sample; then does the same at base−delta and restores base.
- Sits between the SPGD update logic, which supplies base and delta, and the offset-binary-to-two's-complement DAC formatter.
- Also handshakes with the ADC/metric capture path.

---
 rtl/spgd_dac_pkg.sv | 47 ++++
 rtl/spgd_dac_perturb_seq_sat_addsub.sv | 42 ++++
 rtl/spgd_dac_perturb_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/spgd_dac_pkg.sv
// Shared definitions for the SPGD DAC perturbation path: the sequencer state
// encoding, phase tags for metric samples, and the DAC code width constants
// that the offset-binary formatter also uses.
package spgd_dac_pkg;

  // DAC code width (unsigned offset-binary) and default settle-counter width
  localparam int SPGD_DAC_W    = 14;
  localparam int SPGD_SETTLE_W = 16;

  // Analog zero on an offset-binary DAC, and the full-scale code
  localparam logic [SPGD_DAC_W-1:0] SPGD_MIDSCALE = 14'h2000;
  localparam logic [SPGD_DAC_W-1:0] SPGD_DAC_MAX  = 14'h3FFF;

  // Sequencer states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PLUS   = 3'd1,
    ST_SAMP_P = 3'd2,
    ST_MINUS  = 3'd3,
    ST_SAMP_M = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_e;

  // Tag carried alongside each metric sample request
  typedef enum logic [1:0] {
    PH_NONE  = 2'd0,
    PH_PLUS  = 2'd1,
    PH_MINUS = 2'd2
  } phase_e;

  // Metric sample is requested in the two sampling states only
  function automatic logic is_sample_state(input seq_state_e s);
    return (s == ST_SAMP_P) || (s == ST_SAMP_M);
  endfunction

  // Phase tag implied by a state: plus side, minus side, or none
  function automatic phase_e phase_of(input seq_state_e s);
    phase_e ph;
    case (s)
      ST_PLUS,  ST_SAMP_P: ph = PH_PLUS;
      ST_MINUS, ST_SAMP_M: ph = PH_MINUS;
      default:             ph = PH_NONE;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/spgd_dac_perturb_seq_sat_addsub.sv
// Saturating add/subtract of an unsigned perturbation onto an unsigned
// offset-binary DAC code. Both results are formed one bit wider than the code
// so the carry (add) or borrow (subtract) bit flags the out-of-range case.
module sat_addsub
  import spgd_dac_pkg::*;
#(
  parameter int W = SPGD_DAC_W
) (
  input  logic [W-1:0] u_i,
  input  logic [W-1:0] d_i,
  input  logic         sub_i,
  output logic [W-1:0] code_o,
  output logic         sat_o
);

  logic [W:0] sum_w;
  logic [W:0] diff_w;

  // Widened sum/difference, then clamp to [0, 2^W-1] and flag the clamp
  always_comb begin
    sum_w  = {1'b0, u_i} + {1'b0, d_i};
    diff_w = {1'b0, u_i} - {1'b0, d_i};
    code_o = u_i;
    sat_o  = 1'b0;
    if (sub_i) begin
      if (diff_w[W]) begin
        code_o = '0;
        sat_o  = 1'b1;
      end else begin
        code_o = diff_w[W-1:0];
      end
    end else begin
      if (sum_w[W]) begin
        code_o = '1;
        sat_o  = 1'b1;
      end else begin
        code_o = sum_w[W-1:0];
      end
    end
  end

endmodule

// File: rtl/spgd_dac_perturb_seq.sv
// Two-sided SPGD perturbation sequencer for one DAC channel. Each accepted
// start drives base+delta, settles, requests a metric sample, then does the
// same at base-delta and finally restores base. Every output is a register
// loaded from the next-state decode, so outputs change together with the
// state they describe and no input reaches an output combinationally.
module spgd_dac_perturb_seq
  import spgd_dac_pkg::*;
#(
  parameter int                    WIRE_WIDTH = SPGD_DAC_W,
  parameter int                    SETTLE_W   = SPGD_SETTLE_W,
  parameter logic [WIRE_WIDTH-1:0] MIDSCALE   = WIRE_WIDTH'(SPGD_MIDSCALE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WIRE_WIDTH-1:0] base_code,
  input  logic [WIRE_WIDTH-1:0] delta,
  input  logic [SETTLE_W-1:0]   settle_cycles,
  input  logic                  sample_ack,
  output logic                  sample_req,
  output logic [1:0]            phase,
  output logic [WIRE_WIDTH-1:0] dac_code,
  output logic                  busy,
  output logic                  done,
  output logic                  sat
);

  seq_state_e state_q, state_d;

  logic [SETTLE_W-1:0]   cnt_q, cnt_d;
  logic [WIRE_WIDTH-1:0] u_q, u_d;
  logic [WIRE_WIDTH-1:0] d_q, d_d;
  logic [SETTLE_W-1:0]   s_q, s_d;

  logic [WIRE_WIDTH-1:0] dac_q, dac_d;
  phase_e                phase_q, phase_d;
  logic                  req_q, req_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  sat_q, sat_d;

  logic                  start_acc;
  logic [WIRE_WIDTH-1:0] op_u, op_d;
  logic                  op_sub;
  logic [WIRE_WIDTH-1:0] as_code;
  logic                  as_sat;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, settle counter and operand latching
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    u_d       = u_q;
    d_d       = d_q;
    s_d       = s_q;
    start_acc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // start beats a coincident abort: abort has nothing to stop here
        if (start) begin
          start_acc = 1'b1;
          state_d   = ST_PLUS;
          cnt_d     = settle_cycles;
          u_d       = base_code;
          d_d       = delta;
          s_d       = settle_cycles;
        end
      end
      ST_PLUS: begin
        if (cnt_q == '0) state_d = ST_SAMP_P;
        else             cnt_d   = cnt_q - SETTLE_W'(1);
      end
      ST_SAMP_P: begin
        if (sample_ack) begin
          state_d = ST_MINUS;
          cnt_d   = s_q;
        end
      end
      ST_MINUS: begin
        if (cnt_q == '0) state_d = ST_SAMP_M;
        else             cnt_d   = cnt_q - SETTLE_W'(1);
      end
      ST_SAMP_M: begin
        if (sample_ack) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Abort overrides any pending ack; DONE is already on its way to IDLE
    if (abort && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      state_d = ST_DONE;
    end
  end

  // Operands come straight from the ports on the accepting cycle so the plus
  // code is ready one edge after start; afterwards the latched copies are used
  assign op_u   = start_acc ? base_code : u_q;
  assign op_d   = start_acc ? delta     : d_q;
  assign op_sub = (state_d == ST_MINUS);

  sat_addsub #(
    .W (WIRE_WIDTH)
  ) u_sat_addsub (
    .u_i    (op_u),
    .d_i    (op_d),
    .sub_i  (op_sub),
    .code_o (as_code),
    .sat_o  (as_sat)
  );

  // Output decode from the state being entered
  always_comb begin
    dac_d   = dac_q;
    sat_d   = sat_q;
    phase_d = phase_of(state_d);
    req_d   = is_sample_state(state_d);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    case (state_d)
      ST_PLUS, ST_MINUS: begin
        dac_d = as_code;
        // a new sequence forgets clamps from the previous one
        sat_d = (start_acc ? 1'b0 : sat_q) | as_sat;
      end
      ST_DONE: begin
        dac_d = u_q;
      end
      default: begin
        dac_d = dac_q;
      end
    endcase
  end

  // Datapath registers: counter and latched sequence parameters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      u_q   <= '0;
      d_q   <= '0;
      s_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      u_q   <= u_d;
      d_q   <= d_d;
      s_q   <= s_d;
    end
  end

  // Registered outputs; reset parks the DAC at analog zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_q   <= MIDSCALE;
      phase_q <= PH_NONE;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      dac_q   <= dac_d;
      phase_q <= phase_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
    end
  end

  assign dac_code   = dac_q;
  assign phase      = phase_q;
  assign sample_req = req_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sat        = sat_q;

endmodule
